// File: rtl/serial_mult_ctrl_pkg.sv
// Shared definitions for the serial multiplier sequencer slice:
// operand/product width defaults, burst length and controller state encoding.
package serial_mult_ctrl_pkg;

   localparam int unsigned DFLT_NB_DATA_IN  = 4;
   localparam int unsigned DFLT_NB_DATA_OUT = 2 * DFLT_NB_DATA_IN;
   localparam int unsigned MULT_BURST       = 2 * DFLT_NB_DATA_IN;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/serial_mult.sv
// Bit-serial unsigned multiplier: operands arrive LSB-first during an 8-cycle
// enable burst, product bit k is presented combinationally in burst cycle k.
module serial_mult
   import serial_mult_ctrl_pkg::*;
#(
   parameter int unsigned NB_DATA_IN = DFLT_NB_DATA_IN
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_data_a,
   input  logic i_data_b,
   output logic o_data
);

   localparam int unsigned NB_CNT = $clog2(MULT_BURST);
   localparam int unsigned NB_OUT = 2 * NB_DATA_IN;

   logic [NB_CNT-1:0]     cnt;
   logic [NB_DATA_IN-1:0] a_q, b_q, a_cur, b_cur;
   logic [NB_OUT-1:0]     p_cur;

   // Product bit k only depends on operand bits 0..k, so the partial operands suffice.
   always_comb begin
      a_cur = a_q;
      b_cur = b_q;
      if (cnt < NB_CNT'(NB_DATA_IN)) begin
         a_cur = a_q | (NB_DATA_IN'(i_data_a) << cnt);
         b_cur = b_q | (NB_DATA_IN'(i_data_b) << cnt);
      end
      p_cur  = NB_OUT'(a_cur) * NB_OUT'(b_cur);
      o_data = i_en & p_cur[cnt];
   end

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt <= '0;
         a_q <= '0;
         b_q <= '0;
      end else if (i_en) begin
         cnt <= cnt + 1'b1;
         if (cnt == NB_CNT'(MULT_BURST - 1)) begin
            a_q <= '0;
            b_q <= '0;
         end else begin
            a_q <= a_cur;
            b_q <= b_cur;
         end
      end
   end

endmodule

// File: rtl/serial_mult_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves past the winner
// only when a grant is actually issued.
module rr_arb2 (
   input  logic       clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt,
   output logic       o_gnt_id
);

   logic ptr;
   logic pick;

   always_comb begin
      pick  = (i_req == 2'b11) ? ptr : i_req[1];
      o_gnt = '0;
      if (i_en && (|i_req)) begin
         o_gnt = pick ? 2'b10 : 2'b01;
      end
      o_gnt_id = pick;
   end

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         ptr <= 1'b0;
      end else if (|o_gnt) begin
         ptr <= ~pick;
      end
   end

endmodule

// File: rtl/serial_mult_ctrl.sv
// Sequencer for the shared bit-serial multiplier: arbitrates two parallel
// requesters, runs one 8-cycle serial burst and returns the parallel product.
module serial_mult_ctrl
   import serial_mult_ctrl_pkg::*;
#(
   parameter int unsigned NB_DATA_IN  = DFLT_NB_DATA_IN,
   parameter int unsigned NB_DATA_OUT = DFLT_NB_DATA_OUT
) (
   input  logic                    clk,
   input  logic                    i_rst,
   input  logic [1:0]              i_req_valid,
   output logic [1:0]              o_req_ready,
   input  logic [2*NB_DATA_IN-1:0] i_op_a,
   input  logic [2*NB_DATA_IN-1:0] i_op_b,
   output logic                    o_res_valid,
   input  logic                    i_res_ready,
   output logic [NB_DATA_OUT-1:0]  o_res_data,
   output logic                    o_res_id,
   output logic                    o_mult_en,
   output logic                    o_mult_a,
   output logic                    o_mult_b,
   input  logic                    i_mult_data
);

   localparam int unsigned BURST  = 2 * NB_DATA_IN;
   localparam int unsigned NB_CNT = $clog2(BURST);

   ctrl_state_t           state, state_nxt;
   logic [NB_DATA_IN-1:0] a_sh, b_sh;
   logic [NB_DATA_OUT-1:0] prod;
   logic [NB_CNT-1:0]     cnt;
   logic                  res_id;
   logic [1:0]            gnt;
   logic                  gnt_id;
   logic                  arb_en;

   // Gated by reset so no grant is visible while reset is held.
   assign arb_en = (state == IDLE) && i_rst;

   rr_arb2 u_arb (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_en     (arb_en),
      .i_req    (i_req_valid),
      .o_gnt    (gnt),
      .o_gnt_id (gnt_id)
   );

   assign o_req_ready = gnt;
   assign o_res_data  = prod;
   assign o_res_id    = res_id;

   always_comb begin
      state_nxt   = state;
      o_mult_en   = 1'b0;
      o_mult_a    = 1'b0;
      o_mult_b    = 1'b0;
      o_res_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (|gnt) state_nxt = RUN;
         end
         RUN: begin
            o_mult_en = 1'b1;
            if (cnt < NB_CNT'(NB_DATA_IN)) begin
               o_mult_a = a_sh[0];
               o_mult_b = b_sh[0];
            end
            if (cnt == NB_CNT'(BURST - 1)) state_nxt = DONE;
         end
         DONE: begin
            o_res_valid = 1'b1;
            if (i_res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         prod   <= '0;
         cnt    <= '0;
         res_id <= 1'b0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (|gnt) begin
                  a_sh   <= gnt_id ? i_op_a[2*NB_DATA_IN-1:NB_DATA_IN] : i_op_a[NB_DATA_IN-1:0];
                  b_sh   <= gnt_id ? i_op_b[2*NB_DATA_IN-1:NB_DATA_IN] : i_op_b[NB_DATA_IN-1:0];
                  res_id <= gnt_id;
                  cnt    <= '0;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               prod <= {i_mult_data, prod[NB_DATA_OUT-1:1]};
               cnt  <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Self-checking bench for serial_mult_ctrl driving a serial_mult instance,
// with a transaction-level model of grant, burst timing and product value.
module tb_serial_mult_ctrl;

   logic       clk;
   logic       i_rst;
   logic [1:0] i_req_valid;
   logic [1:0] o_req_ready;
   logic [7:0] i_op_a;
   logic [7:0] i_op_b;
   logic       o_res_valid;
   logic       i_res_ready;
   logic [7:0] o_res_data;
   logic       o_res_id;
   logic       o_mult_en;
   logic       o_mult_a;
   logic       o_mult_b;
   logic       i_mult_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   serial_mult_ctrl #(.NB_DATA_IN(4), .NB_DATA_OUT(8)) dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_op_a      (i_op_a),
      .i_op_b      (i_op_b),
      .o_res_valid (o_res_valid),
      .i_res_ready (i_res_ready),
      .o_res_data  (o_res_data),
      .o_res_id    (o_res_id),
      .o_mult_en   (o_mult_en),
      .o_mult_a    (o_mult_a),
      .o_mult_b    (o_mult_b),
      .i_mult_data (i_mult_data)
   );

   serial_mult #(.NB_DATA_IN(4)) u_mult (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_en     (o_mult_en),
      .i_data_a (o_mult_a),
      .i_data_b (o_mult_b),
      .o_data   (i_mult_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Transaction model: a grant at cycle g implies enable in g+1..g+8 and a
   // held result from g+9 until accepted; products are plain A*B.
   logic [7:0] log_data[$];
   logic       log_id[$];
   logic       busy = 1'b0;
   logic       ptr  = 1'b0;
   int         g_cyc = 0;
   logic       m_id;
   logic [3:0] m_a, m_b;
   logic [7:0] m_prod;
   int         en_run = 0;

   always @(negedge clk) begin
      logic [1:0] exp_gnt;
      int         k;
      logic       in_run, in_done, ea, eb;
      if (!i_rst) begin
         chk("reset_outputs", 32'({o_req_ready, o_res_valid, o_res_data, o_res_id,
                                   o_mult_en, o_mult_a, o_mult_b}), 32'd0);
         busy   = 1'b0;
         ptr    = 1'b0;
         en_run = 0;
      end else begin
         exp_gnt = 2'b00;
         if (!busy && i_req_valid != 2'b00)
            exp_gnt = (i_req_valid == 2'b11) ? (ptr ? 2'b10 : 2'b01) : i_req_valid;
         chk("req_ready", 32'(o_req_ready), 32'(exp_gnt));
         k       = cyc - g_cyc - 1;
         in_run  = busy && k >= 0 && k < 8;
         in_done = busy && k >= 8;
         ea = 1'b0;
         eb = 1'b0;
         if (in_run && k < 4) begin
            ea = m_a[k[1:0]];
            eb = m_b[k[1:0]];
         end
         chk("mult_en", 32'(o_mult_en), 32'(in_run));
         chk("mult_a", 32'(o_mult_a), 32'(ea));
         chk("mult_b", 32'(o_mult_b), 32'(eb));
         chk("res_valid", 32'(o_res_valid), 32'(in_done));
         if (in_done) begin
            chk("res_data", 32'(o_res_data), 32'(m_prod));
            chk("res_id", 32'(o_res_id), 32'(m_id));
         end
         if (o_mult_en) begin
            en_run++;
         end else begin
            if (en_run != 0) chk("en_run_len", 32'(en_run), 32'd8);
            en_run = 0;
         end
         if (exp_gnt != 2'b00) begin
            busy   = 1'b1;
            g_cyc  = cyc;
            m_id   = exp_gnt[1];
            m_a    = m_id ? i_op_a[7:4] : i_op_a[3:0];
            m_b    = m_id ? i_op_b[7:4] : i_op_b[3:0];
            m_prod = {4'b0, m_a} * {4'b0, m_b};
            ptr    = ~m_id;
         end else if (in_done && i_res_ready) begin
            log_data.push_back(o_res_data);
            log_id.push_back(o_res_id);
            busy = 1'b0;
         end
      end
   end

   // One cycle of stimulus: requesters drop valid once their grant is seen.
   task automatic step(output logic [1:0] g);
      @(negedge clk);
      g = o_req_ready & i_req_valid;
      @(posedge clk);
      #1;
      i_req_valid = i_req_valid & ~g;
   endtask

   task automatic run_until_results(input int target, input int budget);
      logic [1:0] g;
      for (int i = 0; i < budget; i++) begin
         step(g);
         if (log_data.size() >= target) return;
      end
      chk("timeout_results", 32'(log_data.size()), 32'(target));
   endtask

   task automatic run_until_grant(input int r, input int budget);
      logic [1:0] g;
      for (int i = 0; i < budget; i++) begin
         step(g);
         if (g[r]) return;
      end
      chk("timeout_grant", 32'd0, 32'd1);
   endtask

   task automatic set_op(input int r, input logic [3:0] a, input logic [3:0] b);
      if (r == 0) begin
         i_op_a[3:0] = a;
         i_op_b[3:0] = b;
      end else begin
         i_op_a[7:4] = a;
         i_op_b[7:4] = b;
      end
      i_req_valid[r] = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n, en_cnt;
      logic [1:0] g;
      i_rst       = 1'b0;
      i_req_valid = 2'b00;
      i_op_a      = '0;
      i_op_b      = '0;
      i_res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'({o_req_ready, o_res_valid, o_res_data, o_res_id,
                              o_mult_en, o_mult_a, o_mult_b}), 32'd0);
      i_rst = 1'b1;

      // 15*15 with latency measured from grant edge to valid.
      set_op(0, 4'hF, 4'hF);
      run_until_grant(0, 20);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (o_res_valid) break;
      end
      chk("latency_to_valid", 32'(n), 32'd9);
      run_until_results(1, 20);
      chk("p0_data", 32'(log_data[0]), 32'hE1);
      chk("p0_id", 32'(log_id[0]), 32'd0);

      set_op(1, 4'h5, 4'h3);
      run_until_results(2, 30);
      set_op(1, 4'h0, 4'hB);
      run_until_results(3, 30);
      chk("p1_data", 32'(log_data[1]), 32'h0F);
      chk("p1_id", 32'(log_id[1]), 32'd1);
      chk("p2_data", 32'(log_data[2]), 32'h00);

      // Both requesters valid straight out of reset: pointer starts at 0.
      @(posedge clk); #1;
      i_rst = 1'b0;
      set_op(0, 4'h2, 4'h3);
      set_op(1, 4'h4, 4'h4);
      @(posedge clk); #1;
      i_rst = 1'b1;
      base = log_data.size();
      run_until_results(base + 2, 60);
      chk("both_first_data", 32'(log_data[base]), 32'h06);
      chk("both_first_id", 32'(log_id[base]), 32'd0);
      chk("both_second_data", 32'(log_data[base+1]), 32'h10);
      chk("both_second_id", 32'(log_id[base+1]), 32'd1);

      // Back-pressure in DONE with req0 already waiting again.
      base = log_data.size();
      i_res_ready = 1'b0;
      set_op(0, 4'h3, 4'h5);
      run_until_grant(0, 20);
      set_op(0, 4'h6, 4'h6);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_res_valid) break;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_data", 32'(o_res_data), 32'h0F);
         chk("hold_no_grant", 32'({o_req_ready, o_mult_en}), 32'd0);
      end
      @(posedge clk); #1;
      i_res_ready = 1'b1;
      run_until_results(base + 2, 40);
      chk("bp_first", 32'(log_data[base]), 32'h0F);
      chk("bp_second", 32'(log_data[base+1]), 32'h24);

      // Reset in the middle of a burst (k=4) discards the product.
      base = log_data.size();
      set_op(0, 4'hA, 4'hB);
      en_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         g = o_req_ready & i_req_valid;
         if (o_mult_en) en_cnt++;
         if (en_cnt == 5) break;
         @(posedge clk); #1;
         i_req_valid = i_req_valid & ~g;
      end
      chk("reached_k4", 32'(en_cnt), 32'd5);
      #1;
      i_rst = 1'b0;
      #1;
      chk("midrun_reset_outputs", 32'({o_req_ready, o_res_valid, o_res_data, o_res_id,
                                       o_mult_en, o_mult_a, o_mult_b}), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_rst = 1'b1;
      set_op(0, 4'h7, 4'h9);
      run_until_results(base + 1, 30);
      chk("after_reset_count", 32'(log_data.size()), 32'(base + 1));
      chk("after_reset_data", 32'(log_data[base]), 32'h3F);

      // All 256 operand pairs, requesters alternating, issued back to back.
      base = log_data.size();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] iv;
         iv = 8'(i);
         set_op(i % 2, iv[7:4], iv[3:0]);
         run_until_grant(i % 2, 30);
      end
      run_until_results(base + 256, 30);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] iv;
         logic [7:0] exp_p;
         iv    = 8'(i);
         exp_p = {4'b0, iv[7:4]} * {4'b0, iv[3:0]};
         if (base + i < log_data.size()) begin
            chk("sweep_data", 32'(log_data[base+i]), 32'(exp_p));
            chk("sweep_id", 32'(log_id[base+i]), 32'(i % 2));
         end else begin
            chk("sweep_missing", 32'(log_data.size()), 32'(base + 256));
         end
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_mult_ctrl.md
# serial_mult_ctrl

Sequencer and two-port arbiter for the bit-serial 4x4 multiplier (`serial_mult`). It accepts parallel U(4,3) operand pairs from two requesters and grants one round-robin. It shifts the granted operands LSB-first into the multiplier during one complete 8-cycle enable burst and collects the serial product back into a parallel U(8,6) word, returned with a valid/ready handshake. It sits between the parallel datapath clients and the single shared serial multiplier instance.

## Interface
Parameters:
- `NB_DATA_IN`, 4, operand width (U(4,3)); must match the multiplier instance
- `NB_DATA_OUT`, 8, product width (U(8,6)); equals 2*`NB_DATA_IN`

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `i_rst`  in  1  reset, asynchronous, active-low; the multiplier instance shares this reset
- `i_req_valid`  in  2  per-requester operand valid
- `o_req_ready`  out  2  per-requester grant/accept; at most one bit set
- `i_op_a`  in  2*NB_DATA_IN  operand A; requester r occupies bits [r*NB_DATA_IN +: NB_DATA_IN]
- `i_op_b`  in  2*NB_DATA_IN  operand B; same packing
- `o_res_valid`  out  1  product available
- `i_res_ready`  in  1  consumer accepts product
- `o_res_data`  out  NB_DATA_OUT  product
- `o_res_id`  out  1  index of the requester that owns `o_res_data`
- `o_mult_en`  out  1  to multiplier `i_en`
- `o_mult_a`  out  1  to multiplier `i_data_a`
- `o_mult_b`  out  1  to multiplier `i_data_b`
- `i_mult_data`  in  1  from multiplier `o_data`

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - If any `i_req_valid` is set, grant requester g per round-robin: priority pointer p (reset 0), so requester p wins when both are valid.
  - Assert `o_req_ready[g]` combinationally in this cycle; the handshake completes on this edge.
  - Load A/B shift registers from g's slice, set `o_res_id`<=g, set p<=~g, clear bit counter, go to RUN.
- RUN, bit counter k=0..7:
  - `o_mult_en`=1.
  - For k<4: `o_mult_a`=A[k] and `o_mult_b`=B[k]. For k>=4: both are 0.
  - Each cycle capture `i_mult_data` into product shift register: prod <= {i_mult_data, prod[7:1]}. Bit k lands at prod[k] after the burst.
  - At k=7, go to DONE.
- DONE:
  - `o_res_valid`=1; `o_res_data`/`o_res_id` are stable.
  - On `i_res_ready`=1, go to IDLE.
  - No grant occurs in RUN or DONE.
- `o_mult_en` is only ever high for exactly 8 consecutive cycles, so the multiplier's internal 0..7 counter stays aligned with k. The burst is never aborted except by reset.
- Width rule: the product is an unsigned full 8-bit result with no truncation or saturation. The binary point moves from 3+3 to 6.

## Timing
- Reset values:
  - `o_req_ready`=0, `o_res_valid`=0, `o_res_data`=0, `o_res_id`=0
  - `o_mult_en`=0, `o_mult_a`=0, `o_mult_b`=0
  - Pointer p=0.
- Latency: grant in cycle N, `o_mult_en` high N+1..N+8, `o_res_valid` high from N+9.
- Maximum throughput is one product per 10 cycles with `i_res_ready` held high.
- A requester must hold valid and operands stable until its ready bit is seen. Dropping valid before grant is legal and is simply not served.
- Product bits are sampled in the same cycle as the corresponding `o_mult_en` cycle, because the multiplier's `o_data` is combinational.
- Reset asserted mid-RUN or mid-DONE:
  - All state returns to reset values immediately.
  - The in-flight product is discarded and never reported.
  - The shared multiplier reset realigns its counter.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE/RUN/DONE)
  - `NB_DATA_IN`/`NB_DATA_OUT` defaults
  - Burst length constant `MULT_BURST`=2*`NB_DATA_IN`
- Natural sub-module: `rr_arb2`, a 2-way round-robin arbiter with grant-accept pointer update. The FSM, shift registers and bit counter stay in `serial_mult_ctrl`.
- The bench instantiates `serial_mult_ctrl` together with `serial_mult`.

## Test plan
- Req0 A=0xF, B=0xF -> `o_res_data`=0xE1, id=0, valid exactly 9 cycles after grant.
- Req1 A=0x5, B=0x3 -> 0x0F, id=1; A=0x0, B=0xB -> 0x00.
- Both valid from reset with ops (0x2,0x3) and (0x4,0x4) -> id0 result 0x06 first, then id1 result 0x10; `o_req_ready` is never 2'b11.
- Hold `i_res_ready`=0 for 5 cycles in DONE with req0 still valid -> result stable, no grant, `o_mult_en`=0; grant follows the cycle after accept.
- Assert `i_rst` at RUN k=4 -> all outputs 0 same cycle; the next op 0x7x0x9 returns 0x3F.
- Back-to-back sweep of all 256 operand pairs alternating requesters -> every product matches A*B, and `o_mult_en` high runs are always exactly 8 cycles.
